display_arbiter: RTL and testbench



---
 rtl/display_pkg.sv | 20 ++
 rtl/disp_hold_timer.sv | 53 +++++
 rtl/display_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_display_arbiter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared definitions for the four-digit display arbiter:
//   state_t   - arbiter FSM states (IDLE, SHOW)
//   NDIGITS   - number of hex digits driven to the display controller
//   DIGIT_W   - width of one hex digit
//   DP_RESET  - decimal-point vector after reset (all segments off, active-low)
// -----------------------------------------------------------------------------
package display_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    localparam int NDIGITS = 4;
    localparam int DIGIT_W = 4;
    localparam logic [NDIGITS-1:0] DP_RESET = 4'b1111;

endpackage : display_pkg

// File: rtl/disp_hold_timer.sv
// -----------------------------------------------------------------------------
// disp_hold_timer
// Loadable down-counter that measures how long a granted requester keeps the
// display. It counts down to zero and then stops there; it never wraps.
//
// Parameters:
//   TW     - counter width
// Ports:
//   ck     in   system clock
//   rst_n  in   asynchronous active-low reset (count returns to 0)
//   load   in   load 'value' into the counter on this edge
//   value  in   TW  count to load
//   done   out  high while the count is zero
// -----------------------------------------------------------------------------
module disp_hold_timer
    import display_pkg::*;
#(
    parameter int TW = 8
) (
    input  logic          ck,
    input  logic          rst_n,
    input  logic          load,
    input  logic [TW-1:0] value,
    output logic          done
);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    // Next count: load wins, otherwise decrement and saturate at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = value;
        end else if (count_q != {TW{1'b0}}) begin
            count_d = count_q - TW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {TW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == {TW{1'b0}});

endmodule : disp_hold_timer

// File: rtl/display_arbiter.sv
// -----------------------------------------------------------------------------
// display_arbiter
// Shares the four-digit 7-segment display between two requesters through a
// request/acknowledge handshake. A grant loads the winner's digits and
// decimal points into registered outputs and holds the display for HOLD
// cycles before requests are looked at again.
//
// Build option:
//   DISPLAY_ARB_RR_EN - defined: round-robin between simultaneous requests
//                       (the port that is not the current owner wins).
//                       undefined: fixed priority, port 0 wins.
//
// Parameters:
//   HOLD   - minimum display ownership per grant, in ck cycles (>= 1)
//   TW     - hold-timer width
// Ports:
//   ck, rst_n           clock / asynchronous active-low reset
//   req0, data0, dp0    port 0 request, digits [15:12]->x3..[3:0]->x0, dp
//   ack0                one-cycle grant pulse for port 0
//   req1, data1, dp1    port 1 request, digits, dp
//   ack1                one-cycle grant pulse for port 1
//   x3, x2, x1, x0      registered digits to the display controller
//   dp_out              registered decimal-point vector
//   busy                high while the display is held (SHOW)
//   owner               port index of the last grant
// -----------------------------------------------------------------------------
module display_arbiter
    import display_pkg::*;
#(
    parameter int HOLD = 50_000_000,
    parameter int TW   = $clog2(HOLD) + 1
) (
    input  logic                 ck,
    input  logic                 rst_n,
    input  logic                 req0,
    input  logic [15:0]          data0,
    input  logic [NDIGITS-1:0]   dp0,
    output logic                 ack0,
    input  logic                 req1,
    input  logic [15:0]          data1,
    input  logic [NDIGITS-1:0]   dp1,
    output logic                 ack1,
    output logic [DIGIT_W-1:0]   x3,
    output logic [DIGIT_W-1:0]   x2,
    output logic [DIGIT_W-1:0]   x1,
    output logic [DIGIT_W-1:0]   x0,
    output logic [NDIGITS-1:0]   dp_out,
    output logic                 busy,
    output logic                 owner
);

    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD - 1);

    state_t state_q;
    state_t state_d;

    logic [NDIGITS-1:0][DIGIT_W-1:0] disp_q;
    logic [NDIGITS-1:0][DIGIT_W-1:0] disp_d;
    logic [NDIGITS-1:0]              dp_q;
    logic [NDIGITS-1:0]              dp_d;
    logic                            ack0_q;
    logic                            ack0_d;
    logic                            ack1_q;
    logic                            ack1_d;
    logic                            owner_q;
    logic                            owner_d;

    logic grant_s;
    logic win_s;
    logic timer_done_s;

    disp_hold_timer #(
        .TW (TW)
    ) u_hold_timer (
        .ck    (ck),
        .rst_n (rst_n),
        .load  (grant_s),
        .value (HOLD_LOAD),
        .done  (timer_done_s)
    );

    // Arbitration: requests are only considered while IDLE.
    always_comb begin
        grant_s = (state_q == IDLE) && (req0 || req1);
`ifdef DISPLAY_ARB_RR_EN
        // On a contest the port that does not currently own the display wins.
        if (req0 && req1) begin
            win_s = ~owner_q;
        end else if (req0) begin
            win_s = 1'b0;
        end else begin
            win_s = 1'b1;
        end
`else
        if (req0) begin
            win_s = 1'b0;
        end else begin
            win_s = 1'b1;
        end
`endif
    end

    // FSM state register.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a grant starts SHOW, an expired timer ends it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_s) begin
                    state_d = SHOW;
                end else begin
                    state_d = IDLE;
                end
            end
            SHOW: begin
                if (timer_done_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = SHOW;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM outputs: capture the winner's value on a grant, otherwise hold.
    always_comb begin
        disp_d  = disp_q;
        dp_d    = dp_q;
        owner_d = owner_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        if (grant_s) begin
            owner_d = win_s;
            if (win_s == 1'b0) begin
                disp_d = data0;
                dp_d   = dp0;
                ack0_d = 1'b1;
            end else begin
                disp_d = data1;
                dp_d   = dp1;
                ack1_d = 1'b1;
            end
        end else begin
            disp_d  = disp_q;
            dp_d    = dp_q;
            owner_d = owner_q;
        end
    end

    // Output registers.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            disp_q  <= {(NDIGITS*DIGIT_W){1'b0}};
            dp_q    <= DP_RESET;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            owner_q <= 1'b1;
        end else begin
            disp_q  <= disp_d;
            dp_q    <= dp_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            owner_q <= owner_d;
        end
    end

    assign x3     = disp_q[3];
    assign x2     = disp_q[2];
    assign x1     = disp_q[1];
    assign x0     = disp_q[0];
    assign dp_out = dp_q;
    assign ack0   = ack0_q;
    assign ack1   = ack1_q;
    assign owner  = owner_q;
    assign busy   = (state_q == SHOW);

endmodule : display_arbiter

// File: tb/tb_display_arbiter.sv
// -----------------------------------------------------------------------------
// tb_display_arbiter
// Directed scenarios plus random traffic for display_arbiter with HOLD = 4.
// Expected outputs come from a cycle-count model of the ownership rules.
// -----------------------------------------------------------------------------
module tb_display_arbiter;

    localparam int HOLD = 4;

    logic        ck = 1'b0;
    logic        rst_n;
    logic        req0, req1;
    logic [15:0] data0, data1;
    logic [3:0]  dp0, dp1;
    logic        ack0, ack1;
    logic [3:0]  x3, x2, x1, x0;
    logic [3:0]  dp_out;
    logic        busy, owner;

    display_arbiter #(.HOLD(HOLD)) dut (
        .ck(ck), .rst_n(rst_n),
        .req0(req0), .data0(data0), .dp0(dp0), .ack0(ack0),
        .req1(req1), .data1(data1), .dp1(dp1), .ack1(ack1),
        .x3(x3), .x2(x2), .x1(x1), .x0(x0),
        .dp_out(dp_out), .busy(busy), .owner(owner)
    );

    always #5 ck = ~ck;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    // Reference model: cycles of ownership left, plus the captured value.
    int          hold_left;
    logic [15:0] m_disp;
    logic [3:0]  m_dp;
    logic        m_ack0, m_ack1, m_owner;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        check("ack0",   32'(ack0),              32'(m_ack0));
        check("ack1",   32'(ack1),              32'(m_ack1));
        check("digits", 32'({x3, x2, x1, x0}),  32'(m_disp));
        check("dp_out", 32'(dp_out),            32'(m_dp));
        check("busy",   32'(busy),              32'(hold_left > 0));
        check("owner",  32'(owner),             32'(m_owner));
    endtask

    task automatic model_reset();
        hold_left = 0;
        m_disp    = 16'h0000;
        m_dp      = 4'b1111;
        m_ack0    = 1'b0;
        m_ack1    = 1'b0;
        m_owner   = 1'b1;
    endtask

    task automatic model_edge(input logic r0, input logic [15:0] d0, input logic [3:0] p0,
                              input logic r1, input logic [15:0] d1, input logic [3:0] p1);
        logic w;
        m_ack0 = 1'b0;
        m_ack1 = 1'b0;
        if (hold_left == 0 && (r0 || r1)) begin
`ifdef DISPLAY_ARB_RR_EN
            if (r0 && r1) w = !m_owner;
            else          w = !r0;
`else
            w = !r0;
`endif
            hold_left = HOLD;
            m_owner   = w;
            if (!w) begin m_disp = d0; m_dp = p0; m_ack0 = 1'b1; end
            else    begin m_disp = d1; m_dp = p1; m_ack1 = 1'b1; end
        end else if (hold_left > 0) begin
            hold_left--;
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, compare after it.
    task automatic cycle(input logic r0, input logic [15:0] d0, input logic [3:0] p0,
                         input logic r1, input logic [15:0] d1, input logic [3:0] p1);
        req0 = r0; data0 = d0; dp0 = p0;
        req1 = r1; data1 = d1; dp1 = p1;
        @(posedge ck);
        model_edge(r0, d0, p0, r1, d1, p1);
        cyc++;
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 4'h0, 1'b0, 16'h0, 4'h0);
    endtask

    initial begin
        int a0_cyc;
        int lat;
        int n_ack1;
        int last_ack;
        int gaps_bad;
        int n_grants;

        rst_n = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        data0 = 16'h0; data1 = 16'h0; dp0 = 4'h0; dp1 = 4'h0;
        model_reset();

        // Power-on reset values.
        #2 rst_n = 1'b0;
        #2 check_outputs();
        @(negedge ck) rst_n = 1'b1;
        idle(2);

        // Single grant from port 0, then port 1 raised during the hold.
        cycle(1'b1, 16'h1234, 4'b1110, 1'b0, 16'h0, 4'h0);
        check("grant0_digits", 32'({x3, x2, x1, x0}), 32'h1234);
        a0_cyc = cyc;
        lat = 0;
        for (int i = 0; i < 20 && lat == 0; i++) begin
            cycle(1'b0, 16'h0, 4'h0, 1'b1, 16'hBEEF, 4'b0101);
            if (ack1 === 1'b1) lat = cyc - a0_cyc;
        end
        check("ack1_latency", 32'(lat), 32'(HOLD + 1));
        check("grant1_digits", 32'({x3, x2, x1, x0}), 32'hBEEF);
        idle(HOLD + 2);

        // Abandoned request: port 1 pulses only while port 0 holds the display.
        cycle(1'b1, 16'h5678, 4'b0011, 1'b0, 16'h0, 4'h0);
        n_ack1 = 0;
        cycle(1'b0, 16'h0, 4'h0, 1'b1, 16'hCAFE, 4'b1000);
        if (ack1 === 1'b1) n_ack1++;
        cycle(1'b0, 16'h0, 4'h0, 1'b1, 16'hCAFE, 4'b1000);
        if (ack1 === 1'b1) n_ack1++;
        for (int i = 0; i < HOLD + 2; i++) begin
            idle(1);
            if (ack1 === 1'b1) n_ack1++;
        end
        check("abandoned_ack1", 32'(n_ack1), 32'd0);
        check("abandoned_digits", 32'({x3, x2, x1, x0}), 32'h5678);

        // Simultaneous requests held: grants spaced HOLD+1 cycles apart.
        last_ack = -1; gaps_bad = 0; n_grants = 0;
        for (int i = 0; i < 4 * (HOLD + 1); i++) begin
            cycle(1'b1, 16'h0A0A, 4'b1100, 1'b1, 16'hB0B0, 4'b0011);
            if (ack0 === 1'b1 || ack1 === 1'b1) begin
                if (last_ack >= 0 && cyc - last_ack != HOLD + 1) gaps_bad++;
                last_ack = cyc;
                n_grants++;
            end
        end
        check("contest_grants", 32'(n_grants), 32'd4);
        check("contest_gaps", 32'(gaps_bad), 32'd0);
        idle(HOLD + 2);

        // Reset in the middle of a hold aborts it.
        cycle(1'b1, 16'h9876, 4'b0110, 1'b0, 16'h0, 4'h0);
        idle(1);
        #3 rst_n = 1'b0;
        model_reset();
        #1 check_outputs();
        @(negedge ck) rst_n = 1'b1;
        idle(2);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 2) == 0), 16'($urandom), 4'($urandom),
                  ($urandom_range(0, 2) == 0), 16'($urandom), 4'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_display_arbiter
